// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV M-extension multiply/divide unit sharing one shift datapath,
// with a registered result, kill, and a quotient/remainder reuse cache.
module muldiv_seq #(
    parameter int XLEN     = 32,
    parameter int UNROLL   = 1,
    parameter bit CACHE_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] c_out
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_n;

    logic [2:0]        op;
    logic [XLEN-1:0]   a, b, mc;
    logic [2*XLEN-1:0] acc, nxt, prod;
    logic              neg, n1;
    logic [CW-1:0]     cnt;
    logic              c_valid, c_s;
    logic [XLEN-1:0]   c_a, c_b, c_q, c_r;
    logic              s1, s2, i1, i2, accept, dz, ovf, hit, fast;
    logic [XLEN-1:0]   m1, m2, fast_res, fix_res, q, r, qs, rs;
    logic [XLEN:0]     diff, sum;

    assign s1 = ~(funct3[0] & (funct3[1] | funct3[2]));
    assign s2 = ~((funct3[1] & ~funct3[2]) | (funct3[0] & funct3[2]));
    assign i1 = s1 & rs1[XLEN-1];
    assign i2 = s2 & rs2[XLEN-1];
    assign m1 = i1 ? -rs1 : rs1;
    assign m2 = i2 ? -rs2 : rs2;

    assign busy   = state == CALC || state == FIX;
    assign done   = state == DONE;
    assign accept = start & ~kill & ~busy;

    assign dz   = rs2 == '0;
    assign ovf  = ~funct3[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
    assign hit  = CACHE_EN && c_valid && rs1 == c_a && rs2 == c_b && c_s == ~funct3[0];
    assign fast = funct3[2] & (dz | ovf | hit);
    assign fast_res = dz ? (funct3[1] ? rs1 : '1) : ovf ? (funct3[1] ? '0 : rs1) : (funct3[1] ? c_r : c_q);

    assign prod    = neg ? -acc : acc;
    assign q       = acc[XLEN-1:0];
    assign r       = acc[2*XLEN-1:XLEN];
    assign qs      = neg ? -q : q;
    assign rs      = n1 ? -r : r;
    assign fix_res = op[2] ? (op[1] ? rs : qs) : (op[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        nxt  = acc;
        diff = '0;
        sum  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            diff = nxt[2*XLEN-1:XLEN-1] - {1'b0, mc};
            sum  = {1'b0, nxt[2*XLEN-1:XLEN]} + {1'b0, mc & {XLEN{nxt[0]}}};
            nxt  = op[2] ? (diff[XLEN] ? {nxt[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], nxt[XLEN-2:0], 1'b1})
                         : {sum, nxt[XLEN-1:1]};
        end
    end

    always_comb begin
        state_n = IDLE;
        if (kill)
            state_n = IDLE;
        else if (accept)
            state_n = fast ? DONE : CALC;
        else if (state == CALC)
            state_n = cnt == '0 ? FIX : CALC;
        else if (state == FIX)
            state_n = DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= '0;
            a       <= '0;
            b       <= '0;
            mc      <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            n1      <= 1'b0;
            cnt     <= '0;
            c_out   <= '0;
            c_valid <= 1'b0;
            c_s     <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_q     <= '0;
            c_r     <= '0;
        end else begin
            if (accept) begin
                op  <= funct3;
                a   <= rs1;
                b   <= rs2;
                n1  <= i1;
                neg <= i1 ^ i2;
                acc <= {{XLEN{1'b0}}, funct3[2] ? m1 : m2};
                mc  <= funct3[2] ? m2 : m1;
                cnt <= CW'(N - 1);
            end else if (state == CALC) begin
                acc <= nxt;
                cnt <= cnt - CW'(1);
            end
            if (accept && fast)
                c_out <= fast_res;
            else if (state == FIX && !kill)
                c_out <= fix_res;
            if (kill)
                c_valid <= 1'b0;
            else if (CACHE_EN && state == FIX && op[2]) begin
                c_valid <= 1'b1;
                c_a     <= a;
                c_b     <= b;
                c_s     <= ~op[0];
                c_q     <= qs;
                c_r     <= rs;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq against a plain-arithmetic model
// with a simple operand-match cache predictor.
module tb_muldiv_seq;
    logic        clk = 0, rst = 1, start = 0, kill = 0, start2 = 0, kill2 = 0;
    logic [2:0]  funct3 = 0, f3_2 = 0;
    logic [31:0] rs1 = 0, rs2 = 0, c_out;
    logic [63:0] rs1_2 = 0, rs2_2 = 0, c_out2;
    logic        busy, done, busy2, done2;
    int          tests = 0, fails = 0;
    logic        cv_m = 0, cs_m = 0;
    logic [31:0] ca_m = 0, cb_m = 0, last_out = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32), .UNROLL(1), .CACHE_EN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .c_out(c_out));

    muldiv_seq #(.XLEN(64), .UNROLL(4), .CACHE_EN(1)) dut64 (
        .clk(clk), .rst(rst), .start(start2), .kill(kill2), .funct3(f3_2),
        .rs1(rs1_2), .rs2(rs2_2), .busy(busy2), .done(done2), .c_out(c_out2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        p  = 64'(sx * sy);
        case (f)
            3'd0: return p[31:0];
            3'd1: return p[63:32];
            3'd2: begin p = 64'(sx * longint'(uy)); return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: return y == 0 ? 32'hFFFF_FFFF : 32'(sx / sy);
            3'd5: return y == 0 ? 32'hFFFF_FFFF : 32'(ux / uy);
            3'd6: return y == 0 ? x : 32'(sx % sy);
            default: return y == 0 ? x : 32'(ux % uy);
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // issue one op, optionally poking a stray start while busy; checks latency and result
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int poke);
        logic        ovf, hit, fastp;
        logic [31:0] exp;
        int          lat, exp_lat;
        ovf     = f[2] && !f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
        hit     = f[2] && cv_m && x == ca_m && y == cb_m && cs_m == !f[0];
        fastp   = f[2] && (y == 0 || ovf || hit);
        exp     = model(f, x, y);
        exp_lat = fastp ? 1 : 34;
        if (f[2] && !fastp) begin
            cv_m = 1; ca_m = x; cb_m = y; cs_m = !f[0];
        end
        funct3 = f; rs1 = x; rs2 = y; start = 1;
        @(negedge clk);
        start = 0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
        check($sformatf("busy f%0d %h,%h", f, x, y), 64'(busy), 64'(exp_lat > 1));
        lat = 1;
        while (!done && lat < 100) begin
            start = (lat == poke);
            @(negedge clk);
            lat++;
        end
        start = 0;
        check($sformatf("latency f%0d %h,%h", f, x, y), 64'(lat), 64'(exp_lat));
        check($sformatf("result f%0d %h,%h", f, x, y), 64'(c_out), 64'(exp));
        last_out = exp;
    endtask

    task automatic issue64(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y, input logic [63:0] exp);
        int lat;
        f3_2 = f; rs1_2 = x; rs2_2 = y; start2 = 1;
        @(negedge clk);
        start2 = 0;
        lat = 1;
        while (!done2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency64 f%0d", f), 64'(lat), 64'd18);
        check($sformatf("result64 f%0d", f), c_out2, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] x, y;
        int          n;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset c_out", 64'(c_out), 64'd0);
        check("reset c_out64", c_out2, 64'd0);
        rst = 0;
        @(negedge clk);

        issue(3'd0, 32'hFFFF_FFF9, 32'd3, 0);
        issue(3'd1, 32'hFFFF_FFF9, 32'd3, 0);
        issue(3'd3, 32'hFFFF_FFF9, 32'd3, 0);
        issue(3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(3'd7, 32'h0000_1234, 32'd0, 0);
        issue(3'd5, 32'h0000_DEAD, 32'd0, 0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd7, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd5, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd0, 32'd5, 32'd6, 7);

        issue(3'd5, 32'd100, 32'd7, 0);
        issue(3'd7, 32'd100, 32'd7, 0);
        // kill in DONE drops the cache and swallows a same-cycle start
        kill = 1; start = 1; funct3 = 3'd7;
        @(negedge clk);
        kill = 0; start = 0;
        cv_m = 0;
        check("kill idle busy", 64'(busy), 64'd0);
        check("kill idle done", 64'(done), 64'd0);
        @(negedge clk);

        funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        check("busy before kill", 64'(busy), 64'd1);
        kill = 1;
        @(negedge clk);
        kill = 0;
        check("busy after kill", 64'(busy), 64'd0);
        check("c_out after kill", 64'(c_out), 64'(last_out));
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        check("no done after kill", 64'(n), 64'd0);
        issue(3'd7, 32'd100, 32'd7, 0);
        issue(3'd5, 32'd100, 32'd7, 0);

        funct3 = 3'd0; rs1 = 32'd1234; rs2 = 32'd77; start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst done", 64'(done), 64'd0);
        check("async rst c_out", 64'(c_out), 64'd0);
        @(negedge clk);
        rst = 0;
        cv_m = 0;
        @(negedge clk);
        issue(3'd7, 32'd100, 32'd7, 0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 0);

        x = pick(); y = pick();
        for (int k = 0; k < 60; k++) begin
            f = 3'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                x = pick(); y = pick();
            end
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            issue(f, x, y, $urandom_range(0, 40));
        end

        issue64(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555);
        issue64(3'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFEB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised multi-cycle RISC-V M-extension unit: iterative shift-add multiplier and restoring divider sharing one datapath, XLEN and bits-per-cycle selectable.
- Sits in the execute stage; core issues with start/busy and captures the result on a one-cycle done pulse.
- Adds a registered result, abort (kill), and a bidirectional quotient/remainder cache so DIV→REM and REM→DIV pairs both complete in one cycle.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- UNROLL, 1, bits resolved per iteration cycle; must divide XLEN (1, 2, 4, 8).
- CACHE_EN, 1, 1 enables the quotient/remainder reuse cache; 0 removes it.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  issue request; sampled only when busy=0.
- kill  in  1  abort current operation; has priority over start.
- funct3  in  3  M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  in  XLEN  multiplicand/dividend; latched at accept.
- rs2  in  XLEN  multiplier/divisor; latched at accept.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; c_out is valid from this cycle onward.
- c_out  out  XLEN  registered result; held until the next done.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, c_out=0, cache invalid, all datapath registers cleared.
- States: IDLE, CALC, FIX, DONE. busy = (CALC|FIX). start is accepted in IDLE or DONE, so back-to-back issue is allowed.
- Accept: latch funct3, rs1, rs2, then latch magnitudes:
  - rs1 is signed for funct3 in {0,1,2,4,6}.
  - rs2 is signed for funct3 in {0,1,4,6}.
- Fast path, accept → DONE, done on the next cycle (latency 1):
  - Divisor zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (DIV/REM with rs1 = most-negative, rs2 = -1): DIV → rs1; REM → 0.
  - Cache hit (below).
- Normal path: accept → CALC for XLEN/UNROLL cycles → FIX for 1 cycle (sign correction and select) → DONE. done asserts XLEN/UNROLL+2 cycles after the accept cycle; default latency is 34.
- MUL: produces a 2·XLEN unsigned product of the magnitudes. Negate if the operand signs differ (MULHSU: negate if rs1 is negative). MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DIV: restoring division, UNROLL quotient bits per cycle. Signed quotient is negated when the operand signs differ; signed remainder takes the sign of rs1. A zero remainder stays zero.
- DONE: done=1 and c_out updated for exactly one cycle, then IDLE (or CALC/DONE if a new start is accepted).
- Cache (CACHE_EN=1):
  - Written in FIX of any normal-path divide: stores rs1, rs2, signedness (~funct3[0]), signed-corrected q and r; sets valid.
  - Hit: funct3[2]=1 and rs1, rs2 and signedness all match the stored entry → return the stored q or r.
  - Invalidated by rst and by kill. MUL ops and fast-path divides leave it unchanged.
- kill:
  - In CALC or FIX: next state IDLE, no done, c_out unchanged, cache invalidated.
  - In IDLE or DONE: start that cycle is ignored; cache invalidated.
- start while busy: ignored, no side effect.
- Operand changes after accept do not affect the result.

Test Plan:
- XLEN=32, UNROLL=1, MUL rs1=0xFFFFFFF9 (-7), rs2=3 → done exactly 34 cycles after accept, c_out=0xFFFFFFEB. Repeat with MULH → 0xFFFFFFFF; MULHU → 0x00000002.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → done 1 cycle after accept, c_out=0x80000000. REM with the same operands → 0. REMU rs1=0x1234, rs2=0 → 0x1234 in 1 cycle. DIVU x/0 → 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9, rs2=2 → 34 cycles, c_out=0xFFFFFFFD. Then:
  - REM same operands → 0xFFFFFFFF in 1 cycle (cache hit).
  - REMU same operands → 34 cycles, c_out=1 (signedness mismatch, no hit).
  - DIVU same operands → 1 cycle, 0x7FFFFFFC.
- DIVU 100/7, kill asserted at cycle 10 of CALC → busy=0 next cycle, no done, c_out holds previous value. A following REMU 100/7 takes the full 34 cycles and returns 2.
- rst asserted mid-CALC → busy, done and c_out go to 0 immediately (asynchronous). Back-to-back start in the DONE cycle → accepted, second done 34 cycles later.
- UNROLL=4, XLEN=64: DIVU 0xFFFFFFFFFFFFFFFF / 3 → done 18 cycles after accept, c_out=0x5555555555555555.
